// File: rtl/fetch_pipeline_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pipeline_mem_pkg
// Summary  : Shared sizing defaults and fetch FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pipeline_mem_pkg;

    localparam int c_ADDR_W  = 10;
    localparam int c_DATA_W  = 32;
    localparam int c_DEPTH   = 1024;
    localparam int c_STATE_W = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE         = 3'd0;
    localparam state_t c_ST_FETCH        = 3'd1;
    localparam state_t c_ST_WAIT_MEM     = 3'd2;
    localparam state_t c_ST_OUTPUT       = 3'd3;
    localparam state_t c_ST_WAIT_ACK_LOW = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_pipeline_mem_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Summary  : Single-port RAM shared by the fetch port and an external port,
//            fixed priority to fetch, registered read data, one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import fetch_pipeline_mem_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_ack,
    output logic [DATA_W-1:0]     fetch_do,
    input  logic                  ext_en,
    input  logic                  ext_we,
    input  logic [DATA_W/8-1:0]   ext_be,
    input  logic [ADDR_W-1:0]     ext_addr,
    input  logic [DATA_W-1:0]     ext_di,
    output logic                  ext_ack,
    output logic [DATA_W-1:0]     ext_do
);

    localparam int c_LANES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    logic              r_fetch_ack;
    logic              r_ext_ack;
    logic [DATA_W-1:0] r_fetch_do;
    logic [DATA_W-1:0] r_ext_do;

    logic              w_fetch_gnt;
    logic              w_ext_gnt;
    logic [ADDR_W-1:0] w_addr;

    // The ack cycle blocks a regrant while the requester is still holding ext_en.
    assign w_fetch_gnt = fetch_req;
    assign w_ext_gnt   = ext_en & ~fetch_req & ~r_ext_ack;
    assign w_addr      = w_fetch_gnt ? fetch_addr : ext_addr;

    // Array storage carries no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && w_ext_gnt && ext_we) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (ext_be[b]) begin
                    r_mem[w_addr][b*8 +: 8] <= ext_di[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_ack <= 1'b0;
            r_ext_ack   <= 1'b0;
            r_fetch_do  <= '0;
            r_ext_do    <= '0;
        end else begin
            r_fetch_ack <= w_fetch_gnt;
            r_ext_ack   <= w_ext_gnt;
            if (w_fetch_gnt) begin
                r_fetch_do <= r_mem[w_addr];
            end
            if (w_ext_gnt) begin
                r_ext_do <= r_mem[w_addr];
            end
        end
    end

    assign fetch_ack = r_fetch_ack;
    assign fetch_do  = r_fetch_do;
    assign ext_ack   = r_ext_ack;
    assign ext_do    = r_ext_do;

endmodule
`default_nettype wire

// File: rtl/fetch_pipeline_mem.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipeline_mem
// Summary  : PC-in / instruction-out fetch pipeline over a shared RAM.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pipeline_mem
    import fetch_pipeline_mem_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ack,
    input  logic                  ext_en,
    input  logic                  ext_we,
    input  logic [DATA_W/8-1:0]   ext_be,
    input  logic [ADDR_W-1:0]     ext_addr,
    input  logic [DATA_W-1:0]     ext_di,
    output logic                  ext_ack,
    output logic [DATA_W-1:0]     ext_do
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc_idx;
    logic              r_in_ack;
    logic              r_fetch_req;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_fetch_ack;
    logic [DATA_W-1:0] w_fetch_do;
    logic              w_unused_pc;

    // Byte offset and high PC bits play no part in the word index.
    assign w_unused_pc = ^{in_data[31:ADDR_W+2], in_data[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pc_idx    <= '0;
            r_in_ack    <= 1'b0;
            r_fetch_req <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_in_ack    <= 1'b0;
            r_fetch_req <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_pc_idx <= in_data[ADDR_W+1:2];
                        r_in_ack <= 1'b1;
                        r_state  <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_fetch_req <= 1'b1;
                    r_state     <= c_ST_WAIT_MEM;
                end
                c_ST_WAIT_MEM: begin
                    if (w_fetch_ack) begin
                        r_out_data  <= w_fetch_do;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_OUTPUT;
                    end
                end
                c_ST_OUTPUT: begin
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_ACK_LOW;
                    end
                end
                c_ST_WAIT_ACK_LOW: begin
                    if (!out_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_arbiter (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (r_fetch_req),
        .fetch_addr (r_pc_idx),
        .fetch_ack  (w_fetch_ack),
        .fetch_do   (w_fetch_do),
        .ext_en     (ext_en),
        .ext_we     (ext_we),
        .ext_be     (ext_be),
        .ext_addr   (ext_addr),
        .ext_di     (ext_di),
        .ext_ack    (ext_ack),
        .ext_do     (ext_do)
    );

    assign in_ack    = r_in_ack;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipeline_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pipeline_mem
// Summary  : Directed and randomized bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pipeline_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ack = 1'b0;
    logic        ext_en = 1'b0;
    logic        ext_we = 1'b0;
    logic [3:0]  ext_be = '0;
    logic [9:0]  ext_addr = '0;
    logic [31:0] ext_di = '0;
    logic        ext_ack;
    logic [31:0] ext_do;

    always #5 clk = ~clk;

    fetch_pipeline_mem #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
        .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
        .ext_en(ext_en), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr),
        .ext_di(ext_di), .ext_ack(ext_ack), .ext_do(ext_do)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within bound at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm [1024];
    bit          e_in_ack, e_out_valid, e_ext_ack, e_ext_rd, e_zero;
    logic [31:0] e_out_data, e_ext_do;
    bit          m_idle, m_hold, m_drain, fetch_cyc, n_in_ack, n_out_valid, n_ext_ack;
    int          m_since;
    logic [9:0]  m_pc;
    logic [31:0] m_word;

    initial begin : compare
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        e_in_ack = 0; e_out_valid = 0; e_ext_ack = 0; e_ext_rd = 0; e_zero = 1;
        e_out_data = '0; e_ext_do = '0;
        m_idle = 1; m_hold = 0; m_drain = 0; m_since = 0; m_pc = '0; m_word = '0;
        forever begin
            @(negedge clk);
            chk("in_ack", {31'd0, in_ack}, {31'd0, e_in_ack});
            chk("out_valid", {31'd0, out_valid}, {31'd0, e_out_valid});
            chk("ext_ack", {31'd0, ext_ack}, {31'd0, e_ext_ack});
            if (e_out_valid) chk("out_data", out_data, e_out_data);
            if (e_ext_ack && e_ext_rd) chk("ext_do", ext_do, e_ext_do);
            if (e_zero) begin
                chk("reset_out_data", out_data, 32'd0);
                chk("reset_ext_do", ext_do, 32'd0);
            end
            if (reset) begin
                e_in_ack = 0; e_out_valid = 0; e_ext_ack = 0; e_ext_rd = 0; e_zero = 1;
                e_out_data = '0; e_ext_do = '0;
                m_idle = 1; m_hold = 0; m_drain = 0; m_since = 0;
            end else begin
                // in_ack cycle is m_since==1; the RAM is read for the fetch at 2;
                // out_valid appears three cycles after in_ack.
                e_zero      = 0;
                fetch_cyc   = (m_since == 2);
                n_in_ack    = 0;
                n_out_valid = e_out_valid;
                n_ext_ack   = 0;
                if (fetch_cyc) m_word = mm[m_pc];
                if (m_idle && in_valid) begin
                    n_in_ack = 1; m_idle = 0; m_pc = in_data[11:2]; m_since = 1;
                end else if (m_since == 3) begin
                    n_out_valid = 1; e_out_data = m_word; m_since = 0; m_hold = 1;
                end else if (m_since != 0) begin
                    m_since++;
                end else if (m_hold && out_ack) begin
                    n_out_valid = 0; m_hold = 0; m_drain = 1;
                end else if (m_drain && !out_ack) begin
                    m_drain = 0; m_idle = 1;
                end
                if (ext_en && !fetch_cyc && !e_ext_ack) begin
                    n_ext_ack = 1;
                    e_ext_rd  = !ext_we;
                    if (!ext_we) e_ext_do = mm[ext_addr];
                    else for (int b = 0; b < 4; b++)
                        if (ext_be[b]) mm[ext_addr][8*b +: 8] = ext_di[8*b +: 8];
                end
                e_in_ack = n_in_ack; e_out_valid = n_out_valid; e_ext_ack = n_ext_ack;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + i * 32'h0000_0111;
    endfunction

    task automatic present_pc(input logic [31:0] pc, output bit ok);
        int t = 0;
        in_valid = 1; in_data = pc;
        do begin step(); t++; end while (!in_ack && t < 20);
        ok = in_ack;
        in_valid = 0;
        if (!ok) timeout("in_ack_wait");
    endtask

    task automatic fetch_pc(input logic [31:0] pc, output logic [31:0] word,
                            output int acks, output int lat);
        bit ok;
        int t = 0;
        word = '0; acks = 0; lat = -1;
        present_pc(pc, ok);
        if (!ok) return;
        acks = 1; lat = 0;
        while (!out_valid && t < 20) begin
            step(); lat++; t++;
            if (in_ack) acks++;
        end
        if (!out_valid) begin timeout("out_valid_wait"); return; end
        word = out_data;
        out_ack = 1; step(); if (in_ack) acks++;
        out_ack = 0; step(); if (in_ack) acks++;
    endtask

    task automatic ext_acc(input bit we, input logic [3:0] be, input logic [9:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output bit ok);
        int t = 0;
        ext_en = 1; ext_we = we; ext_be = be; ext_addr = a; ext_di = d;
        do begin step(); t++; end while (!ext_ack && t < 20);
        ok = ext_ack; rd = ext_do;
        ext_en = 0; ext_we = 0;
        if (!ok) timeout("ext_ack_wait");
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] w, rd;
        int          acks, lat, ov_seen, rst_left;
        bit          ok;

        repeat (3) step();
        chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        reset = 0;
        step();

        fetch_pc(32'h0, w, acks, lat);
        chk("first_fetch_data", w, 32'h0);
        chk("first_fetch_acks", acks, 1);
        chk("first_fetch_latency", lat, 3);

        ext_acc(1'b1, 4'b1111, 10'd4, 32'hDEADBEEF, rd, ok);
        chk("ext_write_ack", {31'd0, ok}, 32'd1);
        fetch_pc(32'd16, w, acks, lat);
        chk("fetch_pc16", w, 32'hDEADBEEF);

        ext_acc(1'b1, 4'b0001, 10'd4, 32'h000000AA, rd, ok);
        ext_acc(1'b0, 4'b0000, 10'd4, 32'h0, rd, ok);
        chk("byte_en_readback", rd, 32'hDEADBEAA);
        fetch_pc(32'hFFFF_F013, w, acks, lat);
        chk("fetch_high_bits_ignored", w, 32'hDEADBEAA);

        // Ext request raised in the very cycle the fetch request is issued.
        present_pc(32'd16, ok);
        step();
        ext_en = 1; ext_we = 0; ext_be = 4'h0; ext_addr = 10'd4;
        step();
        chk("collide_ext_ack_deferred", {31'd0, ext_ack}, 32'd0);
        step();
        chk("collide_ext_ack", {31'd0, ext_ack}, 32'd1);
        chk("collide_ext_do", ext_do, 32'hDEADBEAA);
        chk("collide_out_valid", {31'd0, out_valid}, 32'd1);
        chk("collide_out_data", out_data, 32'hDEADBEAA);
        ext_en = 0;
        out_ack = 1; step(); out_ack = 0; step();

        for (int i = 0; i < 8; i++) ext_acc(1'b1, 4'hF, 10'(i), pat(i), rd, ok);
        for (int i = 0; i < 8; i++) begin
            fetch_pc(32'(i * 4), w, acks, lat);
            chk($sformatf("loop_data_%0d", i), w, pat(i));
            chk($sformatf("loop_acks_%0d", i), acks, 1);
        end

        // Reset while the fetch is outstanding.
        present_pc(32'd8, ok);
        step();
        reset = 1; step(); step(); reset = 0;
        ov_seen = 0;
        repeat (6) begin if (out_valid) ov_seen++; step(); end
        chk("reset_wait_mem_no_valid", ov_seen, 0);
        fetch_pc(32'd8, w, acks, lat);
        chk("after_reset_fetch", w, pat(2));
        chk("after_reset_latency", lat, 3);

        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1; rst_left = 2; in_valid = 0; ext_en = 0; out_ack = 0;
            end
            if (!reset) begin
                if (in_valid && in_ack) begin
                    in_valid = ($urandom_range(0, 3) == 0);
                    in_data  = ($urandom & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2);
                end else if (!in_valid && $urandom_range(0, 2) == 0) begin
                    in_valid = 1;
                    in_data  = ($urandom & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2);
                end
                out_ack = ($urandom_range(0, 2) == 0);
                if (ext_en && ext_ack) begin
                    ext_en = 0;
                end else if (!ext_en && $urandom_range(0, 2) == 0) begin
                    ext_en = 1; ext_we = $urandom_range(0, 1) == 1;
                    ext_be = 4'($urandom); ext_addr = 10'($urandom_range(0, 15));
                    ext_di = $urandom;
                end
            end
            step();
        end

        in_valid = 0; ext_en = 0; out_ack = 0; reset = 0;
        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pipeline_mem.md
FETCH_PIPELINE_MEM -- requirements
Module: fetch_pipeline_mem

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word-address width; DATA_W, default 32, data width; DEPTH, default 1024, memory words.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, host presents a PC on in_data (hold until in_ack).
REQ-005 SHALL have port in_data, input, 32, byte PC; word index is in_data[11:2].
REQ-006 SHALL have port in_ack, output, 1, one-cycle pulse when the PC is captured.
REQ-007 SHALL have port out_valid, output, 1, fetched word available.
REQ-008 SHALL have port out_data, output, 32, instruction word read at captured PC.
REQ-009 SHALL have port out_ack, input, 1, host consumed out_data.
REQ-010 SHALL have ports ext_en (in, 1), ext_we (in, 1), ext_be (in, 4), ext_addr (in, 10), ext_di (in, 32), ext_ack (out, 1) and ext_do (out, 32), forming the external memory port.

Function
REQ-011 SHALL contain a DEPTH x 32 single-port RAM shared by two requesters: the internal fetch port and the external port.
REQ-012 SHALL arbitrate with fixed priority, fetch port over external port, granting one request per cycle.
REQ-013 A granted access SHALL complete in 1 cycle: read data is registered; the ack pulses one cycle after grant with data valid in that cycle.
REQ-014 Writes SHALL update only bytes whose ext_be bit is 1 (be[0] -> bits 7:0, ... be[3] -> bits 31:24), and SHALL ack like reads.
REQ-015 External requester SHALL hold ext_en and its signals until ext_ack; an un-granted request SHALL stay pending with no ack.
REQ-016 Pipeline FSM SHALL have states IDLE, FETCH, WAIT_MEM, OUTPUT and WAIT_ACK_LOW.
REQ-017 IDLE: when in_valid=1, SHALL latch in_data[11:2], pulse in_ack for 1 cycle, and go to FETCH.
REQ-018 FETCH: SHALL assert the fetch request, then go to WAIT_MEM.
REQ-019 WAIT_MEM: on fetch ack, SHALL register the read word into out_data, set out_valid=1, and go to OUTPUT.
REQ-020 OUTPUT: SHALL hold out_valid=1 and out_data stable until out_ack=1; it then SHALL clear out_valid next edge and go to WAIT_ACK_LOW.
REQ-021 WAIT_ACK_LOW: SHALL return to IDLE when out_ack=0; no new PC is accepted before this.
REQ-022 in_valid held high while busy SHALL be ignored; no second in_ack is generated.
REQ-023 Addresses SHALL wrap modulo DEPTH; PC bits 31:12 and 1:0 SHALL be ignored.
REQ-024 Simultaneous fetch and external requests SHALL grant the fetch; the external request is served the next free cycle.
REQ-025 Minimum PC-to-out_valid latency SHALL be 3 cycles after the in_ack cycle.

Reset
REQ-026 While reset=1: FSM in IDLE; in_ack, out_valid and ext_ack = 0; out_data and ext_do = 0; arbiter holds no grant.
REQ-027 Reset mid-operation SHALL abandon the fetch and any pending external access, with no ack.
REQ-028 RAM contents SHALL NOT be cleared by reset; they SHALL be initialised to zero at time 0.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef and the ADDR_W/DATA_W/DEPTH defaults.
REQ-030 The RAM plus arbiter SHALL be one sub-module, mem_arbiter; the FSM stays in the top.

Verification
REQ-031 After reset, with in_valid=1 and in_data=0: in_ack pulses once; out_valid rises with out_data=0.
REQ-032 External write of 0xDEADBEEF at addr 4 with be=4'b1111 gets ext_ack; then PC=16 fetch gives out_data=0xDEADBEEF.
REQ-033 Byte-enable write of 0x000000AA with be=4'b0001 over 0xDEADBEEF gives a readback of 0xDEADBEAA.
REQ-034 Host loop with PC=0,4,8,... and 1-cycle out_ack: each PC gives exactly one in_ack and one out_valid, in order, with no duplicates.
REQ-035 With a fetch and ext_en in the same cycle, the fetch is acked first and ext_ack follows one cycle later, with correct data for both.
REQ-036 Reset asserted in WAIT_MEM: out_valid stays 0 and the next PC is accepted normally after reset deasserts.
